mult_scheduler: RTL

- Shares the single combinational 8-bit signed MULT unit between two requesters: the ALU multiply path (REQ0) and the address/offset generation path (REQ1).
- Arbitrates round-robin between them and drives MULT operands from registers.
- Waits a fixed number of cycles for the multiplier's propagation delay to settle, then returns the truncated product to the winner.
- Responses use a valid/ready handshake with backpressure.

---
 rtl/mult_scheduler_pkg.sv | 17 +
 rtl/mult_scheduler_rr_arbiter2.sv | 16 +
 rtl/mult_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/mult_scheduler_pkg.sv
// Shared types and constants for the MULT scheduler.
// State encoding, requester IDs and default widths.
package mult_scheduler_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_AGU = 1'b1;

endpackage

// File: rtl/mult_scheduler_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// VALID0/VALID1: requests; LAST: previous winner; EN: arbitration allowed; GRANT0/GRANT1: one-hot grant.
module rr_arbiter2 (
  input  logic VALID0,
  input  logic VALID1,
  input  logic LAST,
  input  logic EN,
  output logic GRANT0,
  output logic GRANT1
);

  // On a tie the requester that did not win last time goes first.
  assign GRANT0 = EN & VALID0 & (~VALID1 | LAST);
  assign GRANT1 = EN & VALID1 & (~VALID0 | ~LAST);

endmodule

// File: rtl/mult_scheduler.sv
// Shares one combinational MULT unit between the ALU (REQ0) and AGU (REQ1).
// Ports: REQx_* request handshakes, MULT_A/B/OUT to the multiplier, RESP_* result handshake, BUSY.
module mult_scheduler
  import mult_scheduler_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic             REQ1_READY,
  output logic [WIDTH-1:0] MULT_A,
  output logic [WIDTH-1:0] MULT_B,
  input  logic [WIDTH-1:0] MULT_OUT,
  output logic             RESP_VALID,
  output logic             RESP_ID,
  output logic [WIDTH-1:0] RESP_DATA,
  input  logic             RESP_READY,
  output logic             BUSY
);

  // Operands reach the MULT pins only after the accepting edge,
  // so the counter starts one above LATENCY-1 to give LATENCY
  // full settle cycles on top of that first register cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [WIDTH-1:0] r_mult_a;
  logic [WIDTH-1:0] r_mult_b;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_data;

  logic w_en;
  logic w_gnt0;
  logic w_gnt1;

  // RESET gates the grant so READY stays low while held in reset.
  assign w_en = RESET & (r_state == IDLE);

  rr_arbiter2 u_arb (
    .VALID0 (REQ0_VALID),
    .VALID1 (REQ1_VALID),
    .LAST   (r_last),
    .EN     (w_en),
    .GRANT0 (w_gnt0),
    .GRANT1 (w_gnt1)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_mult_a    <= '0;
      r_mult_b    <= '0;
      r_resp_id   <= REQ_ALU;
      r_resp_data <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_mult_a  <= w_gnt1 ? REQ1_A : REQ0_A;
            r_mult_b  <= w_gnt1 ? REQ1_B : REQ0_B;
            r_resp_id <= w_gnt1 ? REQ_AGU : REQ_ALU;
            r_last    <= w_gnt1;
            r_cnt     <= CNT_LOAD;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_resp_data <= MULT_OUT;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (RESP_READY) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign REQ0_READY = w_gnt0;
  assign REQ1_READY = w_gnt1;
  assign MULT_A     = r_mult_a;
  assign MULT_B     = r_mult_b;
  assign RESP_VALID = (r_state == RESP);
  assign RESP_ID    = r_resp_id;
  assign RESP_DATA  = r_resp_data;
  assign BUSY       = (r_state != IDLE);

endmodule
